// File: rtl/tcp_rx_fifo.sv
// Show-ahead receive byte FIFO behind the Tcp block: tags the first byte of each
// segment and counts bytes lost to overflow.
module tcp_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              dataValid,
    input  logic [7:0]        data,
    input  logic              newpkt,
    output logic              outValid,
    output logic [7:0]        outData,
    output logic              outFirst,
    input  logic              outReady,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  dropCount
);

    logic [8:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            first_pending;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic [8:0]      head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign pop   = !empty && outReady;
    assign push  = dataValid && (!full || pop);
    assign drop  = dataValid && full && !pop;

    // Head is read straight from storage so the output never depends on the input byte.
    assign head     = mem[rd_ptr[ADDR_W-1:0]];
    assign outValid = !empty;
    assign outData  = empty ? '0 : head[7:0];
    assign outFirst = !empty && head[8];
    assign level    = wr_ptr - rd_ptr;

    always_ff @(posedge CLOCK) begin
        if (!RESET && push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {first_pending | newpkt, data};
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            first_pending <= 1'b1;
            overflow      <= 1'b0;
            dropCount     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
            // A dropped tagged byte leaves the flag set for the next stored byte.
            if (push) begin
                first_pending <= 1'b0;
            end else if (newpkt) begin
                first_pending <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (dropCount != '1) begin
                    dropCount <= dropCount + CNT_W'(1);
                end
            end
        end
    end

endmodule
